// File: rtl/float2int_pkg.sv
// Shared widths, FSM state encoding and float word packing for the float-to-integer decoder.
// Optional feature macro used by this block: FLOAT2INT_ZSKIP_EN.
package float2int_pkg;

    localparam int EXP_W  = 3;
    localparam int MANT_W = 4;
    localparam int INT_W  = 11;  // must be >= MANT_W + 2**EXP_W - 1

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Same packing as the converter output: exponent in the MSBs.
    typedef struct packed {
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_t;

endpackage

// File: rtl/f2i_shift_unit.sv
// Datapath for the iterative decoder: accumulator, remaining-shift counter and last-shift flag.
// Optional feature macro used by this block: FLOAT2INT_ZSKIP_EN (handled by the caller).
module f2i_shift_unit
    import float2int_pkg::*;
#(
    parameter int EXP_W  = float2int_pkg::EXP_W,
    parameter int MANT_W = float2int_pkg::MANT_W,
    parameter int INT_W  = float2int_pkg::INT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [EXP_W-1:0]  load_exp,
    input  logic [MANT_W-1:0] load_mant,
    output logic [INT_W-1:0]  acc,
    output logic              last
);

    logic [EXP_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= INT_W'(load_mant);
            cnt <= load_exp;
        end else if (shift) begin
            acc <= acc << 1;
            cnt <= cnt - 1'b1;
        end
    end

    // The shift happening while cnt==1 is the final one.
    assign last = (cnt == EXP_W'(1));

endmodule

// File: rtl/float2int_seq.sv
// Sequential float (exp,mant) to integer decoder: out_data = mant << exp, one shift per cycle.
// Optional feature macro: FLOAT2INT_ZSKIP_EN (zero mantissa bypasses the shift loop).
module float2int_seq
    import float2int_pkg::*;
#(
    parameter int EXP_W  = float2int_pkg::EXP_W,
    parameter int MANT_W = float2int_pkg::MANT_W,
    parameter int INT_W  = float2int_pkg::INT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INT_W-1:0]  out_data,
    output state_t            dbg_state
);

    // Handshakes: a transfer occurs on a rising edge where valid && ready are both high.
    // in_ready/out_valid depend only on the state register; sources hold data until accepted,
    // and out_data is held stable while out_valid is high and out_ready is low.

    state_t           state, state_n;
    logic             load, shift, last, zero_skip;
    logic [EXP_W-1:0] ld_exp;

`ifdef FLOAT2INT_ZSKIP_EN
    assign zero_skip = (in_mant == '0);
`else
    assign zero_skip = 1'b0;
`endif

    assign ld_exp = zero_skip ? '0 : in_exp;

    f2i_shift_unit #(
        .EXP_W (EXP_W),
        .MANT_W(MANT_W),
        .INT_W (INT_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift    (shift),
        .load_exp (ld_exp),
        .load_mant(in_mant),
        .acc      (out_data),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_n = ((in_exp == '0) || zero_skip) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: doc/float2int_seq.md
# float2int_seq

Sequential decoder for the 7-bit float format produced by the integer-to-float block: 3-bit exponent plus 4-bit mantissa, in, and 11-bit unsigned integer (mantissa << exponent), out. It sits on the consumer side of the converter and restores integer magnitudes for downstream datapaths and for round-trip checking. It uses a valid/ready handshake on both sides and an iterative one-bit-per-cycle shifter, which keeps area minimal.

## Interface
- EXP_W, default 3: exponent width.
- MANT_W, default 4: mantissa width.
- INT_W, default 11: result width; must be at least MANT_W + 2^EXP_W − 1.
- clk, input, 1: single clock; all state changes on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: input float valid.
- in_ready, output, 1: block can accept; high only in IDLE.
- in_exp, input, EXP_W: exponent field (upper bits of the float word).
- in_mant, input, MANT_W: mantissa field (lower bits of the float word).
- out_valid, output, 1: result valid; high only in DONE.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, INT_W: decoded integer.

## Operation
- Decode rule: out_data = zero_extend(in_mant) << in_exp. Unsigned, no rounding, never overflows given the INT_W constraint.
- FSM states: IDLE, SHIFT, DONE. Internal registers: acc (INT_W) and cnt (EXP_W).
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: acc←mant, cnt←exp.
  - Go to DONE if exp==0, else SHIFT.
- SHIFT:
  - acc←acc<<1, cnt←cnt−1.
  - Go to DONE when cnt==1 (the last shift), else stay.
  - Inputs are ignored; in_ready=0.
- DONE:
  - out_valid=1, out_data=acc, held stable until out_valid && out_ready.
  - On handshake, go to IDLE.
  - No input accepted in the same cycle.
- out_data equals acc in every state. Consumers sample it only when out_valid is high.
- Reset, at any time including mid-SHIFT or mid-DONE:
  - State goes to IDLE; acc=0, cnt=0.
  - The in-flight transaction is discarded, never emitted.
  - Outputs during and after reset: out_valid=0, out_data=0, in_ready=1.

## Timing
- Accept in cycle k, with exponent e:
  - SHIFT occupies cycles k+1 … k+e.
  - out_valid rises in cycle k+e+1.
  - Latency is e+1 cycles: 1 minimum, 8 maximum.
- out_ready high on the first DONE cycle gives IDLE in cycle k+e+2. Minimum initiation interval is e+2 cycles.
- out_ready low holds DONE indefinitely, with out_data stable.
- in_valid asserted outside IDLE has no effect. The source must hold its data until in_ready.
- in_ready and out_valid are decoded combinationally from the state register; they have no combinational path from in_valid or out_ready.

## Configuration
- FLOAT2INT_ZSKIP_EN:
  - Defined: on accept with in_mant==0, go directly to DONE with acc=0 regardless of exponent, so latency is 1.
  - Undefined: zero mantissa is shifted like any other value, taking e+1 cycles. The result is 0 in both cases.

## Structure
- Package float2int_pkg holds:
  - Default widths EXP_W, MANT_W, INT_W.
  - The state enum (IDLE, SHIFT, DONE), 2-bit encoding.
  - A float word typedef: {exp, mant}, exp in the MSBs, matching the converter's output packing.
- One sub-module: f2i_shift_unit, containing acc, cnt, load/shift enables and the last-shift flag. The FSM and handshake stay in the top module.

## Test plan
- Fast path: exp=0, mant=9, out_ready=1 → out_data=9 with out_valid high in cycle k+1; in_ready back high in cycle k+2.
- Maximum shift: exp=7, mant=15 → out_data=1920 in cycle k+8; in_ready=0 for cycles k+1…k+8.
- Backpressure: exp=3, mant=5, out_ready low for 10 cycles → out_valid stays high and out_data stays at 40 throughout; a new in_valid during the stall is not accepted.
- Reset mid-shift: exp=6, mant=1, rst_n low in cycle k+3 → out_valid=0, out_data=0 immediately. The next transaction (exp=2, mant=3) returns 12, and no stale result ever appears.
- Zero mantissa: exp=5, mant=0 → out_data=0. Latency is 1 with FLOAT2INT_ZSKIP_EN defined and 6 without it.
- Round trip: stream all 128 float codes back-to-back, out_ready=1 → each result equals mant<<exp. Each transaction takes exp+2 cycles.
